// File: rtl/ldtu_out_serializer.sv
// LiTe-DTU output serializer: paces FIFO-top reads and shifts each 32-bit word out MSB chunk first.
// Optional word counter port enabled by defining LDTU_SER_WORDCNT_EN.
module ldtu_out_serializer #(
    parameter int                  Nbits_32       = 32,
    parameter int                  LANES          = 4,
    parameter int                  IDLE_THR       = 8,
    parameter logic [Nbits_32-1:0] idle_patternEA = 32'hEAAAAAAA
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic                ser_en,
    input  logic [Nbits_32-1:0] DATA32_DTU,
    output logic                read_signal,
    output logic [LANES-1:0]    ser_out,
    output logic                word_start,
    output logic                link_idle
`ifdef LDTU_SER_WORDCNT_EN
    ,
    output logic [15:0]         word_cnt
`endif
);

    localparam int WORD_CYCLES = Nbits_32 / LANES;
    localparam int PW          = (WORD_CYCLES > 2) ? $clog2(WORD_CYCLES) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(WORD_CYCLES - 1);
    localparam logic [PW-1:0] PH_READ = PW'(WORD_CYCLES - 2);
    localparam logic [7:0]    THR     = 8'(IDLE_THR);

    logic [PW-1:0]       phase_q, phase_d;
    logic [Nbits_32-1:0] shreg_q, shreg_d;
    logic [7:0]          idle_cnt_q, idle_cnt_d;
    logic                link_idle_q, link_idle_d;
`ifdef LDTU_SER_WORDCNT_EN
    logic [15:0]         word_cnt_q, word_cnt_d;
`endif

    always_comb begin
        phase_d     = phase_q;
        shreg_d     = shreg_q;
        idle_cnt_d  = idle_cnt_q;
        link_idle_d = (idle_cnt_q == THR);
`ifdef LDTU_SER_WORDCNT_EN
        word_cnt_d  = word_cnt_q;
`endif
        if (!ser_en) begin
            // Disabled: park on the idle word so re-enable starts with an idle frame
            phase_d = '0;
            shreg_d = idle_patternEA;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
            shreg_d = DATA32_DTU;
            if (DATA32_DTU == idle_patternEA) begin
                if (idle_cnt_q != THR) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end else begin
                idle_cnt_d = '0;
            end
`ifdef LDTU_SER_WORDCNT_EN
            word_cnt_d = word_cnt_q + 16'd1;
`endif
        end else begin
            phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
            shreg_d = shreg_q << LANES;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            phase_q     <= '0;
            shreg_q     <= idle_patternEA;
            idle_cnt_q  <= '0;
            link_idle_q <= 1'b0;
`ifdef LDTU_SER_WORDCNT_EN
            word_cnt_q  <= '0;
`endif
        end else begin
            phase_q     <= phase_d;
            shreg_q     <= shreg_d;
            idle_cnt_q  <= idle_cnt_d;
            link_idle_q <= link_idle_d;
`ifdef LDTU_SER_WORDCNT_EN
            word_cnt_q  <= word_cnt_d;
`endif
        end
    end

    // Strobe one cycle ahead so the FIFO top's registered word is ready for the load edge
    assign read_signal = ser_en && (phase_q == PH_READ);
    assign ser_out     = shreg_q[Nbits_32-1 -: LANES];
    assign word_start  = (phase_q == '0);
    assign link_idle   = link_idle_q;
`ifdef LDTU_SER_WORDCNT_EN
    assign word_cnt    = word_cnt_q;
`endif

endmodule

// File: tb/tb_ldtu_out_serializer.sv
// Self-checking bench for ldtu_out_serializer against a frame-level reference model.
// Covers reset, idle hold, single word, streaming, link_idle, abort, mid-word reset, random enables.
module tb_ldtu_out_serializer;

    localparam int          L    = 4;
    localparam int          WC   = 32 / L;
    localparam int          THR  = 8;
    localparam logic [31:0] IDLE = 32'hEAAAAAAA;

    logic         CLK = 1'b0;
    logic         rst_b;
    logic         ser_en;
    logic [31:0]  DATA32_DTU;
    logic         read_signal;
    logic [L-1:0] ser_out;
    logic         word_start;
    logic         link_idle;
`ifdef LDTU_SER_WORDCNT_EN
    logic [15:0]  word_cnt;
`endif

    ldtu_out_serializer #(
        .Nbits_32(32),
        .LANES(L),
        .IDLE_THR(THR),
        .idle_patternEA(IDLE)
    ) dut (
        .CLK(CLK),
        .rst_b(rst_b),
        .ser_en(ser_en),
        .DATA32_DTU(DATA32_DTU),
        .read_signal(read_signal),
        .ser_out(ser_out),
        .word_start(word_start),
        .link_idle(link_idle)
`ifdef LDTU_SER_WORDCNT_EN
        ,
        .word_cnt(word_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] ref_q[$];

    int          ph;
    logic [31:0] cur_w;
    logic [31:0] nxt_w;
    int          icnt;
    bit          skip_link;
    int unsigned wcnt;

    logic [L-1:0] obs_out;
    bit           obs_rd;

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        ref_q.push_back(w);
    endtask

    task automatic model_reset();
        ph        = 0;
        cur_w     = IDLE;
        nxt_w     = IDLE;
        icnt      = 0;
        skip_link = 0;
        wcnt      = 0;
    endtask

    task automatic cycle(input bit en);
        logic [31:0]  sh;
        logic [L-1:0] exp_out;
        bit           exp_rd;
        bit           exp_ws;
        bit           rd;
        ser_en = en;
        @(negedge CLK);
        sh      = cur_w << (ph * L);
        exp_out = sh[31 -: L];
        exp_ws  = (ph == 0);
        exp_rd  = en && (ph == WC - 2);
        n_cmp++;
        if (ser_out !== exp_out) begin
            n_bad++;
            $display("FAIL ser_out t=%0t got %h want %h", $time, ser_out, exp_out);
        end
        n_cmp++;
        if (word_start !== exp_ws) begin
            n_bad++;
            $display("FAIL word_start t=%0t got %b want %b", $time, word_start, exp_ws);
        end
        n_cmp++;
        if (read_signal !== exp_rd) begin
            n_bad++;
            $display("FAIL read_signal t=%0t got %b want %b", $time, read_signal, exp_rd);
        end
        if (!skip_link) begin
            n_cmp++;
            if (link_idle !== (icnt == THR)) begin
                n_bad++;
                $display("FAIL link_idle t=%0t got %b want %b", $time, link_idle, icnt == THR);
            end
        end
`ifdef LDTU_SER_WORDCNT_EN
        n_cmp++;
        if (word_cnt !== wcnt[15:0]) begin
            n_bad++;
            $display("FAIL word_cnt t=%0t got %0d want %0d", $time, word_cnt, wcnt[15:0]);
        end
`endif
        obs_out = ser_out;
        obs_rd  = read_signal;
        rd      = read_signal;
        @(posedge CLK);
        #1;
        if (rd) DATA32_DTU = (fifo_q.size() > 0) ? fifo_q.pop_front() : IDLE;
        skip_link = 0;
        if (!en) begin
            ph    = 0;
            cur_w = IDLE;
        end else if (ph == WC - 1) begin
            ph        = 0;
            cur_w     = nxt_w;
            skip_link = 1;
            wcnt      = (wcnt + 1) & 32'hFFFF;
            if (nxt_w == IDLE) icnt = (icnt < THR) ? icnt + 1 : THR;
            else icnt = 0;
        end else begin
            if (ph == WC - 2) nxt_w = (ref_q.size() > 0) ? ref_q.pop_front() : IDLE;
            ph++;
        end
    endtask

    task automatic test_reset();
        rst_b      = 1'b0;
        ser_en     = 1'b0;
        DATA32_DTU = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        rst_b = 1'b1;
        model_reset();
        n_cmp++;
        if (ser_out !== 4'hE || word_start !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_out got %h/%b want e/1", ser_out, word_start);
        end
        n_cmp++;
        if (read_signal !== 1'b0 || link_idle !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got rd=%b li=%b want 0/0", read_signal, link_idle);
        end
    endtask

    task automatic test_idle_hold();
        int nrd = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0);
            if (obs_rd) nrd++;
        end
        n_cmp++;
        if (nrd != 0) begin
            n_bad++;
            $display("FAIL idle_hold_reads got %0d want 0", nrd);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] got = '0;
        int first_rd = -1;
        push_word(32'h12345678);
        for (int i = 0; i < WC; i++) begin
            cycle(1'b1);
            if (obs_rd && first_rd < 0) first_rd = i;
        end
        for (int i = 0; i < WC; i++) begin
            cycle(1'b1);
            got = {got[31-L:0], obs_out};
        end
        n_cmp++;
        if (first_rd != WC - 2) begin
            n_bad++;
            $display("FAIL first_read got %0d want %0d", first_rd, WC - 2);
        end
        n_cmp++;
        if (got !== 32'h12345678) begin
            n_bad++;
            $display("FAIL single_word got %h want 12345678", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        int nrd = 0;
        base = $urandom;
        for (int i = 0; i < 100; i++) push_word(base + 32'(i));
        for (int i = 0; i < 100 * WC; i++) begin
            cycle(1'b1);
            if (obs_rd) nrd++;
        end
        n_cmp++;
        if (nrd != 100) begin
            n_bad++;
            $display("FAIL stream_reads got %0d want 100", nrd);
        end
    endtask

    task automatic test_link_idle();
        int n;
        push_word(32'h2CF0F0F0);
        for (int i = 0; i < THR - 1; i++) push_word(IDLE);
        push_word(32'h0BADF00D);
        for (int i = 0; i < THR; i++) push_word(IDLE);
        push_word(32'h2CF0F0F0);
        n = ref_q.size();
        for (int i = 0; i < (n + 1) * WC + 2; i++) cycle(1'b1);
    endtask

    task automatic test_abort();
        logic [19:0] got = '0;
        push_word(32'hDEADBEEF);
        push_word(32'h13579BDF);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        for (int i = 0; i < WC; i++) cycle(1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            got = {got[15:0], obs_out};
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0);
            if (i < 2) got = {got[15:0], obs_out};
        end
        n_cmp++;
        if (got !== 20'hDEADE) begin
            n_bad++;
            $display("FAIL abort_seq got %h want deade", got);
        end
        for (int i = 0; i < 3 * WC; i++) cycle(1'b1);
    endtask

    task automatic test_midword_reset();
        push_word(32'hCAFEF00D);
        push_word(32'h2468ACE0);
        for (int i = 0; i < WC + 3; i++) cycle(1'b1);
        ser_en = 1'b1;
        rst_b  = 1'b0;
        @(posedge CLK);
        #1;
        rst_b = 1'b1;
        model_reset();
        n_cmp++;
        if (ser_out !== 4'hE || word_start !== 1'b1) begin
            n_bad++;
            $display("FAIL midword_reset got %h/%b want e/1", ser_out, word_start);
        end
        for (int i = 0; i < 3 * WC; i++) cycle(1'b1);
    endtask

    task automatic test_random();
        bit en;
        for (int i = 0; i < 600; i++) begin
            if (ref_q.size() < 4) begin
                if ($urandom_range(0, 3) == 0) push_word(IDLE);
                else push_word($urandom);
            end
            en = ($urandom_range(0, 15) != 0);
            cycle(en);
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_single_word();
        test_back_to_back();
        test_link_idle();
        test_abort();
        test_midword_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
